// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if: host port, coefficient SRAM port and filter-side coefficient/enable signals.
interface fir_coeff_loader_if #(parameter int DW = 16, parameter int AW = 6);
    logic          iCoeffiUpdateFlag;
    logic          iCsnRam;
    logic          iWrnRam;
    logic [AW-1:0] iAddrRam;
    logic [DW-1:0] iWrDtRam;
    logic [5:0]    iNumOfCoeff;
    logic [DW-1:0] iRdDtRam;
    logic          oCsnRam;
    logic          oWrnRam;
    logic [AW-1:0] oAddrRam;
    logic [DW-1:0] oWrDtRam;
    logic          oCoeffWrEn;
    logic [AW-1:0] oCoeffIdx;
    logic [DW-1:0] oCoeffDt;
    logic          oEnAcc;
    logic          oBusy;
    logic          oLoadDone;

    modport slave (
        input  iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iNumOfCoeff, iRdDtRam,
        output oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oCoeffWrEn, oCoeffIdx, oCoeffDt,
               oEnAcc, oBusy, oLoadDone
    );

    modport master (
        output iCoeffiUpdateFlag, iCsnRam, iWrnRam, iAddrRam, iWrDtRam, iNumOfCoeff, iRdDtRam,
        input  oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oCoeffWrEn, oCoeffIdx, oCoeffDt,
               oEnAcc, oBusy, oLoadDone
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: forwards host writes to the coefficient SRAM, then burst-loads it into the
// filter coefficient bank, masking taps beyond the active count and gating the accumulator.
module fir_coeff_loader #(
    parameter int NUM_TAP = 33,
    parameter int DW      = 16,
    parameter int AW      = 6
) (
    input logic iClk_12M,
    input logic iRsn,
    fir_coeff_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, UPDATE, RUN, LOAD, DRAIN} stateT;

    stateT         state, stateNxt;
    logic          csnNxt, wrnNxt;
    logic [AW-1:0] addrNxt;
    logic [DW-1:0] wrDtNxt;
    logic [6:0]    nLat;
    logic          lastRd, loadEntry;

    assign lastRd    = bus.oAddrRam == AW'(NUM_TAP - 1);
    assign loadEntry = state == UPDATE && !bus.iCoeffiUpdateFlag;

    always_ff @(posedge iClk_12M or negedge iRsn)
        if (!iRsn) state <= IDLE;
        else       state <= stateNxt;

    always_comb begin
        stateNxt = state;
        csnNxt   = 1'b1;
        wrnNxt   = 1'b1;
        addrNxt  = bus.oAddrRam;
        wrDtNxt  = bus.oWrDtRam;
        case (state)
            IDLE, RUN: stateNxt = bus.iCoeffiUpdateFlag ? UPDATE : state;
            UPDATE: begin
                if (bus.iCoeffiUpdateFlag) begin
                    csnNxt  = bus.iCsnRam | (7'(bus.iAddrRam) >= 7'(NUM_TAP));
                    wrnNxt  = bus.iWrnRam;
                    addrNxt = bus.iAddrRam;
                    wrDtNxt = bus.iWrDtRam;
                end else begin
                    stateNxt = LOAD;
                    csnNxt   = 1'b0;
                    addrNxt  = '0;
                end
            end
            // oAddrRam doubles as the read counter; the read on the last address ends the burst
            LOAD: begin
                stateNxt = lastRd ? DRAIN : LOAD;
                csnNxt   = lastRd;
                addrNxt  = lastRd ? bus.oAddrRam : bus.oAddrRam + 1'b1;
            end
            DRAIN:   stateNxt = RUN;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk_12M or negedge iRsn)
        if (!iRsn) begin
            bus.oCsnRam    <= 1'b1;
            bus.oWrnRam    <= 1'b1;
            bus.oAddrRam   <= '0;
            bus.oWrDtRam   <= '0;
            bus.oCoeffWrEn <= 1'b0;
            bus.oCoeffIdx  <= '0;
            bus.oLoadDone  <= 1'b0;
            nLat           <= '0;
        end else begin
            bus.oCsnRam    <= csnNxt;
            bus.oWrnRam    <= wrnNxt;
            bus.oAddrRam   <= addrNxt;
            bus.oWrDtRam   <= wrDtNxt;
            bus.oCoeffWrEn <= state == LOAD;
            bus.oCoeffIdx  <= state == LOAD ? bus.oAddrRam : bus.oCoeffIdx;
            bus.oLoadDone  <= state == DRAIN;
            nLat           <= !loadEntry ? nLat :
                              (7'(bus.iNumOfCoeff) > 7'(NUM_TAP)) ? 7'(NUM_TAP) : 7'(bus.iNumOfCoeff);
        end

    // read data arrives combinationally in the writeback cycle, so masking happens here
    assign bus.oCoeffDt = (bus.oCoeffWrEn && 7'(bus.oCoeffIdx) < nLat) ? bus.iRdDtRam : '0;
    assign bus.oEnAcc   = state == RUN;
    assign bus.oBusy    = state == UPDATE || state == LOAD || state == DRAIN;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: scoreboard bench with a behavioural SRAM; expected writeback words are
// queued when a load is started and popped on every oCoeffWrEn pulse.
module tb_fir_coeff_loader;
    typedef struct {int idx; logic [15:0] dt;} expT;

    logic        clk = 1'b0;
    logic        rsn;
    logic [15:0] mem [64];
    logic [15:0] shadow [33];
    expT         q[$];
    expT         e;
    int          tests = 0, fails = 0, pulses = 0;

    fir_coeff_loader_if #(.DW(16), .AW(6)) bus();

    fir_coeff_loader #(.NUM_TAP(33), .DW(16), .AW(6)) dut (
        .iClk_12M(clk),
        .iRsn(rsn),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!bus.oCsnRam) begin
            if (!bus.oWrnRam) mem[bus.oAddrRam] <= bus.oWrDtRam;
            else              bus.iRdDtRam      <= mem[bus.oAddrRam];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (bus.oCoeffWrEn) begin
            pulses++;
            if (q.size() == 0) chk("extra_pulse", 1, 0);
            else begin
                e = q.pop_front();
                chk("wb_idx", 32'(bus.oCoeffIdx), e.idx);
                chk("wb_data", 32'(bus.oCoeffDt), 32'(e.dt));
            end
        end

    task automatic enterUpdate();
        bus.iCoeffiUpdateFlag = 1'b1;
        @(negedge clk);
        chk("upd_busy", 32'(bus.oBusy), 1);
        chk("upd_enacc", 32'(bus.oEnAcc), 0);
    endtask

    task automatic hostWrite(input int a, input logic [15:0] d);
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iAddrRam = 6'(a); bus.iWrDtRam = d;
        @(negedge clk);
        bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
        chk("fwd_csn", 32'(bus.oCsnRam), a < 33 ? 0 : 1);
        if (a < 33) begin
            chk("fwd_addr", 32'(bus.oAddrRam), a);
            chk("fwd_data", 32'(bus.oWrDtRam), 32'(d));
            shadow[a] = d;
        end
    endtask

    task automatic pushExpected(input int num);
        int nl;
        nl = num > 33 ? 33 : num;
        for (int k = 0; k < 33; k++) q.push_back('{k, k < nl ? shadow[k] : 16'h0});
    endtask

    task automatic runLoad(input int num, input int reAt);
        int cnt;
        bus.iNumOfCoeff = 6'(num);
        bus.iCoeffiUpdateFlag = 1'b0;
        pulses = 0;
        pushExpected(num);
        cnt = 0;
        while (cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == reAt) bus.iCoeffiUpdateFlag = 1'b1;
            if (cnt == 2) chk("load_busy", 32'(bus.oBusy), 1);
            if (bus.oLoadDone) break;
        end
        chk("load_latency", cnt - 1, 34);
        chk("load_pulses", pulses, 33);
        chk("load_enacc", 32'(bus.oEnAcc), 1);
        chk("load_queue", q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;
        for (int i = 0; i < 33; i++) shadow[i] = 16'h0;
        rsn = 1'b0;
        bus.iCoeffiUpdateFlag = 1'b0; bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1;
        bus.iAddrRam = '0; bus.iWrDtRam = '0; bus.iNumOfCoeff = '0; bus.iRdDtRam = '0;
        repeat (3) @(negedge clk);
        chk("rst_csn", 32'(bus.oCsnRam), 1);
        chk("rst_wrn", 32'(bus.oWrnRam), 1);
        chk("rst_addr", 32'(bus.oAddrRam), 0);
        chk("rst_wdt", 32'(bus.oWrDtRam), 0);
        chk("rst_wren", 32'(bus.oCoeffWrEn), 0);
        chk("rst_idx", 32'(bus.oCoeffIdx), 0);
        chk("rst_dt", 32'(bus.oCoeffDt), 0);
        chk("rst_enacc", 32'(bus.oEnAcc), 0);
        chk("rst_busy", 32'(bus.oBusy), 0);
        chk("rst_done", 32'(bus.oLoadDone), 0);
        rsn = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(bus.oBusy), 0);
        chk("idle_enacc", 32'(bus.oEnAcc), 0);

        enterUpdate();
        for (int k = 0; k < 33; k++) hostWrite(k, 16'(k + 1));
        runLoad(33, 0);

        enterUpdate();
        hostWrite(40, 16'hBEEF);
        runLoad(10, 0);

        enterUpdate();
        runLoad(33, 5);
        @(negedge clk);
        chk("rerun_enacc", 32'(bus.oEnAcc), 0);
        chk("rerun_busy", 32'(bus.oBusy), 1);

        bus.iNumOfCoeff = 6'd33;
        bus.iCoeffiUpdateFlag = 1'b0;
        pulses = 0;
        pushExpected(33);
        repeat (13) @(negedge clk);
        #1 chk("abort_pulses_before", pulses, 12);
        rsn = 1'b0;
        #1;
        chk("abort_wren", 32'(bus.oCoeffWrEn), 0);
        chk("abort_csn", 32'(bus.oCsnRam), 1);
        chk("abort_addr", 32'(bus.oAddrRam), 0);
        chk("abort_idx", 32'(bus.oCoeffIdx), 0);
        chk("abort_dt", 32'(bus.oCoeffDt), 0);
        chk("abort_enacc", 32'(bus.oEnAcc), 0);
        chk("abort_busy", 32'(bus.oBusy), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rsn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_abort_enacc", 32'(bus.oEnAcc), 0);
            chk("post_abort_busy", 32'(bus.oBusy), 0);
        end
        chk("abort_pulses_after", pulses, 12);

        enterUpdate();
        runLoad(50, 0);
        repeat (3) @(negedge clk);
        chk("final_enacc", 32'(bus.oEnAcc), 1);
        chk("final_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-update sequencer for the transposed reconfigurable FIR filter. It owns the single-port coefficient SRAM. During host update mode it forwards host writes into the SRAM. When update mode ends, it reads every SRAM word back in a pipelined burst and drives it into the filter's coefficient register bank, zeroing taps beyond the programmed tap count. It gates the filter accumulator enable, so the datapath never runs on a partially loaded coefficient set.

## Interface
- NUM_TAP, 33, number of coefficient SRAM words and coefficient registers (1..63)
- DW, 16, coefficient width
- AW, 6, SRAM/index address width
- iClk_12M  in  1  single clock, all state on rising edge
- iRsn  in  1  reset, asynchronous, active-low
- iCoeffiUpdateFlag  in  1  level; 1 = host update mode requested
- iCsnRam  in  1  host chip select, active-low
- iWrnRam  in  1  host write-not (0 = write, 1 = read)
- iAddrRam  in  AW  host SRAM address
- iWrDtRam  in  DW  host write data
- iNumOfCoeff  in  6  active tap count; sampled on LOAD entry
- iRdDtRam  in  DW  SRAM read data, valid one cycle after a read is issued
- oCsnRam  out  1  SRAM chip select, active-low, registered
- oWrnRam  out  1  SRAM write-not, registered
- oAddrRam  out  AW  SRAM address, registered
- oWrDtRam  out  DW  SRAM write data, registered
- oCoeffWrEn  out  1  coefficient register write strobe
- oCoeffIdx  out  AW  coefficient index 0..NUM_TAP-1 (index k drives tap k+1)
- oCoeffDt  out  DW  coefficient data
- oEnAcc  out  1  filter accumulator/delay enable
- oBusy  out  1  high in UPDATE, LOAD, DRAIN
- oLoadDone  out  1  one-cycle pulse when a load completes

## Operation
- States: IDLE, UPDATE, RUN, LOAD, DRAIN. Reset state is IDLE.
- IDLE: oEnAcc=0. When iCoeffiUpdateFlag=1, go to UPDATE.
- RUN: oEnAcc=1. When iCoeffiUpdateFlag=1, go to UPDATE; oEnAcc is 0 from the first UPDATE cycle.
- UPDATE: each host access is registered and forwarded one cycle later: oCsnRam<=iCsnRam, oWrnRam<=iWrnRam, oAddrRam<=iAddrRam, oWrDtRam<=iWrDtRam.
  - Accesses with iAddrRam >= NUM_TAP are dropped: oCsnRam<=1.
  - When iCoeffiUpdateFlag=0, go to LOAD with counter k=0.
- LOAD: each cycle issues a read: oCsnRam=0, oWrnRam=1, oAddrRam=k, then k++. After k=NUM_TAP-1 is issued, go to DRAIN. Host port inputs are ignored.
- DRAIN: one cycle to capture the last word. Then go to RUN with oLoadDone=1 for that transition cycle.
- Writeback: the cycle after read address k is presented, oCoeffWrEn=1 and oCoeffIdx=k.
  - oCoeffDt = iRdDtRam when k < Nlat, else 0. Nlat is iNumOfCoeff latched on LOAD entry, clamped to NUM_TAP.
  - Nlat=0 loads all zeros; the load still completes normally.
- iCoeffiUpdateFlag during LOAD or DRAIN is ignored. It is evaluated again in RUN; if still 1, UPDATE is entered one cycle after RUN.
- Outside UPDATE and LOAD: oCsnRam=1, oWrnRam=1. oCoeffWrEn=0 except during writeback cycles.

## Timing
- Reset values: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoeffWrEn=0, oCoeffIdx=0, oCoeffDt=0, oEnAcc=0, oBusy=0, oLoadDone=0.
- Asynchronous reset mid-LOAD aborts the load immediately. The outputs take their reset values, no further oCoeffWrEn pulses occur, and the block returns to IDLE.
- Host to SRAM forwarding latency: 1 cycle.
- LOAD entry to first oCoeffWrEn: 1 cycle. oCoeffWrEn pulses on NUM_TAP consecutive cycles.
- LOAD entry to RUN: NUM_TAP+1 cycles, NUM_TAP=33 gives 34 cycles. oEnAcc rises on the same edge as oLoadDone.
- Flag falling edge to LOAD entry: 1 cycle.

## Test plan
- Reset, then flag=1; host writes 0x0001..0x0021 to addresses 0..32; flag=0 with iNumOfCoeff=33 -> 33 consecutive oCoeffWrEn pulses with idx 0..32 and data 0x0001..0x0021; oLoadDone at cycle 34 after LOAD entry; oEnAcc=1 afterwards.
- Same SRAM contents, iNumOfCoeff=10 -> idx 0..9 carry data, idx 10..32 carry 0x0000.
- In UPDATE, host write to address 40 -> oCsnRam stays 1; SRAM contents are unchanged on the next load.
- Flag reasserted in the 5th LOAD cycle -> load completes all 33 pulses, oLoadDone fires, RUN lasts 1 cycle, then UPDATE with oEnAcc=0.
- Reset asserted after 12 writeback pulses -> all outputs at reset values asynchronously, no further pulses, state IDLE, oEnAcc=0 until the next full load.
- iNumOfCoeff=50 -> clamped to 33; all 33 words are loaded unmasked.
